naxi_slave_responder: RTL and testbench

- Synthesizable Naxi slave (responder) for the cache verification environment: the RTL end that a Naxi master bench drives.
- Accepts commands on the creq channel and write data on the dreq channel, and returns read data on the rreq channel, backed by a small internal word memory.
- Used as the downstream memory model under cache DUTs and as a reference target for master-side agents.

---
 rtl/naxi_slave_responder.sv | 258 +++++++++++++++++++++++++
 tb/tb_naxi_slave_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/naxi_slave_responder.sv
// Naxi slave responder: queued read/write commands served from a small word memory.
// Optional sticky error reporting on errStatus is compiled in with NAXI_SLV_ERRCHK_EN.
module naxi_slave_responder #(
    parameter int NXADDRWIDTH = 31,
    parameter int NXDATAWIDTH = 256,
    parameter int NXIDWIDTH   = 4,
    parameter int NXTYPEWIDTH = 3,
    parameter int NXSIZEWIDTH = 8,
    parameter int NXATTRWIDTH = 3,
    parameter int MEMDEPTH    = 64,
    parameter int QDEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NXADDRWIDTH-1:0] creqAddr,
    input  logic [NXATTRWIDTH-1:0] creqAttr,
    input  logic [NXSIZEWIDTH-1:0] creqSize,
    input  logic [NXIDWIDTH-1:0]   creqId,
    input  logic [NXTYPEWIDTH-1:0] creqType,
    input  logic                   creqValid,
    output logic                   creqRdStall,
    output logic                   creqWrStall,
    input  logic [NXDATAWIDTH-1:0] dreqData,
    input  logic [NXATTRWIDTH-1:0] dreqAttr,
    input  logic [NXIDWIDTH-1:0]   dreqId,
    input  logic                   dreqValid,
    output logic                   dreqStall,
    output logic [NXDATAWIDTH-1:0] rreqData,
    output logic [NXATTRWIDTH-1:0] rreqAttr,
    output logic [NXIDWIDTH-1:0]   rreqId,
    output logic                   rreqValid,
    input  logic                   rreqStall,
    output logic [2:0]             errStatus
);

    localparam int MIDX = $clog2(MEMDEPTH);
    localparam int QW   = $clog2(QDEPTH);
    localparam logic [QW:0] QFULL = (QW+1)'(QDEPTH);

    typedef struct packed {
        logic [MIDX-1:0]        addr;
        logic [NXSIZEWIDTH-1:0] size;
        logic [NXIDWIDTH-1:0]   id;
        logic [NXATTRWIDTH-1:0] attr;
    } cmd_t;

    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_SEND} rd_state_t;
    typedef enum logic       {WR_IDLE, WR_DATA} wr_state_t;

    logic [NXDATAWIDTH-1:0] mem [MEMDEPTH];

    cmd_t cmdIn;
    assign cmdIn = '{addr: creqAddr[MIDX-1:0], size: creqSize, id: creqId, attr: creqAttr};

    logic isRead, isWrite;
    assign isRead  = (creqType == NXTYPEWIDTH'(1));
    assign isWrite = (creqType == NXTYPEWIDTH'(2));

    // ---------------- read command FIFO ----------------
    cmd_t          rdQ [QDEPTH];
    logic [QW-1:0] rdWp, rdRp;
    logic [QW:0]   rdCount;
    logic          rdPush, rdPop;
    cmd_t          rdHead;

    assign rdPush      = creqValid && isRead && !creqRdStall;
    assign rdHead      = rdQ[rdRp];
    assign creqRdStall = (rdCount == QFULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            rdWp    <= '0;
            rdRp    <= '0;
            rdCount <= '0;
        end else begin
            if (rdPush) begin
                rdQ[rdWp] <= cmdIn;
                rdWp      <= rdWp + 1'b1;
            end
            if (rdPop) rdRp <= rdRp + 1'b1;
            rdCount <= rdCount + (QW+1)'(rdPush) - (QW+1)'(rdPop);
        end
    end

    // ---------------- write command FIFO ----------------
    cmd_t          wrQ [QDEPTH];
    logic [QW-1:0] wrWp, wrRp;
    logic [QW:0]   wrCount;
    logic          wrPush, wrPop;
    cmd_t          wrHead;

    assign wrPush      = creqValid && isWrite && !creqWrStall;
    assign wrHead      = wrQ[wrRp];
    assign creqWrStall = (wrCount == QFULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrWp    <= '0;
            wrRp    <= '0;
            wrCount <= '0;
        end else begin
            if (wrPush) begin
                wrQ[wrWp] <= cmdIn;
                wrWp      <= wrWp + 1'b1;
            end
            if (wrPop) wrRp <= wrRp + 1'b1;
            wrCount <= wrCount + (QW+1)'(wrPush) - (QW+1)'(wrPop);
        end
    end

    // ---------------- write engine ----------------
    wr_state_t              wrState, wrNext;
    logic [MIDX-1:0]        wrAddr;
    logic [NXSIZEWIDTH-1:0] wrSize, wrBeat;
    logic [NXIDWIDTH-1:0]   wrId;
    logic                   memWe;
    logic [MIDX-1:0]        wrIdx;

    assign wrIdx = wrAddr + MIDX'(wrBeat);

    always_comb begin
        wrNext    = wrState;
        wrPop     = 1'b0;
        memWe     = 1'b0;
        dreqStall = 1'b1;
        case (wrState)
            WR_IDLE: begin
                if (wrCount != '0) begin
                    wrPop  = 1'b1;
                    wrNext = WR_DATA;
                end
            end
            WR_DATA: begin
                dreqStall = 1'b0;
                if (dreqValid) begin
                    memWe = 1'b1;
                    if (wrBeat == wrSize) wrNext = WR_IDLE;
                end
            end
            default: wrNext = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrState <= WR_IDLE;
            wrAddr  <= '0;
            wrSize  <= '0;
            wrBeat  <= '0;
            wrId    <= '0;
        end else begin
            wrState <= wrNext;
            if (wrPop) begin
                wrAddr <= wrHead.addr;
                wrSize <= wrHead.size;
                wrId   <= wrHead.id;
                wrBeat <= '0;
            end else if (memWe) begin
                wrBeat <= wrBeat + 1'b1;
            end
        end
    end

    // Memory is never reset; a beat presented during rst is dropped.
    always_ff @(posedge clk) begin
        if (memWe && !rst) mem[wrIdx] <= dreqData;
    end

    // ---------------- read engine ----------------
    rd_state_t              rdState, rdNext;
    logic [MIDX-1:0]        rdAddr;
    logic [NXSIZEWIDTH-1:0] rdSize, rdBeat;
    logic                   rdFetch, rdAdvance;
    logic [MIDX-1:0]        rdIdx;

    assign rdIdx     = rdAddr + MIDX'(rdBeat);
    assign rreqValid = (rdState == RD_SEND);

    always_comb begin
        rdNext    = rdState;
        rdPop     = 1'b0;
        rdFetch   = 1'b0;
        rdAdvance = 1'b0;
        case (rdState)
            RD_IDLE: begin
                if (rdCount != '0) begin
                    rdPop  = 1'b1;
                    rdNext = RD_FETCH;
                end
            end
            RD_FETCH: begin
                rdFetch = 1'b1;
                rdNext  = RD_SEND;
            end
            RD_SEND: begin
                if (!rreqStall) begin
                    if (rdBeat == rdSize) begin
                        rdNext = RD_IDLE;
                    end else begin
                        rdAdvance = 1'b1;
                        rdNext    = RD_FETCH;
                    end
                end
            end
            default: rdNext = RD_IDLE;
        endcase
    end

    // rreqData/Id/Attr only change on pop or fetch, so they hold while stalled in SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdState  <= RD_IDLE;
            rdAddr   <= '0;
            rdSize   <= '0;
            rdBeat   <= '0;
            rreqId   <= '0;
            rreqAttr <= '0;
            rreqData <= '0;
        end else begin
            rdState <= rdNext;
            if (rdPop) begin
                rdAddr   <= rdHead.addr;
                rdSize   <= rdHead.size;
                rreqId   <= rdHead.id;
                rreqAttr <= rdHead.attr;
                rdBeat   <= '0;
            end else if (rdAdvance) begin
                rdBeat <= rdBeat + 1'b1;
            end
            if (rdFetch) rreqData <= mem[rdIdx];
        end
    end

    // ---------------- error status ----------------
`ifdef NAXI_SLV_ERRCHK_EN
    logic [1:0] errFlags;

    always_ff @(posedge clk) begin
        if (rst) begin
            errFlags <= 2'b00;
        end else begin
            if (creqValid && !isRead && !isWrite) errFlags[0] <= 1'b1;
            if (memWe && (dreqId != wrId))         errFlags[1] <= 1'b1;
        end
    end

    assign errStatus = {1'b0, errFlags};

    logic unusedBits;
    assign unusedBits = ^{dreqAttr, creqAddr, wrHead.attr};
`else
    assign errStatus = 3'b000;

    logic unusedBits;
    assign unusedBits = ^{dreqAttr, creqAddr, wrHead.attr, dreqId, wrId};
`endif

endmodule

// File: tb/tb_naxi_slave_responder.sv
// Directed bench for naxi_slave_responder: write/read, wrap, back-pressure, FIFO full,
// errors (when NAXI_SLV_ERRCHK_EN is defined) and reset mid-burst.
module tb_naxi_slave_responder;

    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [30:0]   creqAddr;
    logic [2:0]    creqAttr;
    logic [7:0]    creqSize;
    logic [3:0]    creqId;
    logic [2:0]    creqType;
    logic          creqValid;
    logic          creqRdStall, creqWrStall;
    logic [DW-1:0] dreqData;
    logic [2:0]    dreqAttr;
    logic [3:0]    dreqId;
    logic          dreqValid;
    logic          dreqStall;
    logic [DW-1:0] rreqData;
    logic [2:0]    rreqAttr;
    logic [3:0]    rreqId;
    logic          rreqValid;
    logic          rreqStall;
    logic [2:0]    errStatus;

    naxi_slave_responder dut (
        .clk(clk), .rst(rst),
        .creqAddr(creqAddr), .creqAttr(creqAttr), .creqSize(creqSize), .creqId(creqId),
        .creqType(creqType), .creqValid(creqValid),
        .creqRdStall(creqRdStall), .creqWrStall(creqWrStall),
        .dreqData(dreqData), .dreqAttr(dreqAttr), .dreqId(dreqId), .dreqValid(dreqValid),
        .dreqStall(dreqStall),
        .rreqData(rreqData), .rreqAttr(rreqAttr), .rreqId(rreqId), .rreqValid(rreqValid),
        .rreqStall(rreqStall), .errStatus(errStatus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] wr_q[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the edge that captured the command.
    task automatic send_cmd(input logic [2:0] t, input logic [30:0] a, input logic [7:0] s,
                            input logic [3:0] id, input logic [2:0] at);
        logic acc;
        acc = 1'b0;
        creqType = t; creqAddr = a; creqSize = s; creqId = id; creqAttr = at;
        creqValid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = (t == 3'd1) ? !creqRdStall : (t == 3'd2) ? !creqWrStall : 1'b1;
            tick();
        end
        creqValid = 1'b0;
        if (!acc) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic write_burst(input logic [3:0] did);
        int n;
        for (int i = 0; i < 30 && dreqStall; i++) tick();
        check("wr_ready", dreqStall, 0);
        n = wr_q.size();
        for (int b = 0; b < n; b++) begin
            dreqData  = wr_q.pop_front();
            dreqId    = did;
            dreqValid = 1'b1;
            tick();
        end
        dreqValid = 1'b0;
        check("wr_done_stall", dreqStall, 1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !rreqValid; i++) tick();
        check(tag, rreqValid, 1);
    endtask

    task automatic read_expect(input int nb, input logic [3:0] id, input logic [2:0] at);
        rreqStall = 1'b0;
        wait_valid("rd_wait");
        for (int b = 0; b < nb; b++) begin
            check("rd_data", rreqData, exp_q.pop_front());
            check("rd_id", rreqId, id);
            check("rd_attr", rreqAttr, at);
            tick();
            check(b < nb - 1 ? "rd_gap" : "rd_end", rreqValid, 0);
            if (b < nb - 1) tick();
        end
    endtask

    initial begin
        rst = 1'b1; creqValid = 1'b0; creqAddr = '0; creqAttr = '0; creqSize = '0;
        creqId = '0; creqType = '0; dreqData = '0; dreqAttr = '0; dreqId = '0;
        dreqValid = 1'b0; rreqStall = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_rdstall", creqRdStall, 0);
        check("rst_wrstall", creqWrStall, 0);
        check("rst_dstall", dreqStall, 1);
        check("rst_rvalid", rreqValid, 0);
        check("rst_rdata", rreqData, 0);
        check("rst_rid", rreqId, 0);
        check("rst_rattr", rreqAttr, 0);
        check("rst_err", errStatus, 0);

        // Single write then read, with latency
        send_cmd(3'd2, 31'd5, 8'd0, 4'd3, 3'd1);
        wr_q.push_back(256'hA5);
        write_burst(4'd3);
        send_cmd(3'd1, 31'd5, 8'd0, 4'd7, 3'd4);
        check("lat_t0", rreqValid, 0);
        tick();
        check("lat_t1", rreqValid, 0);
        tick();
        check("lat_t2", rreqValid, 1);
        exp_q.push_back(256'hA5);
        read_expect(1, 4'd7, 3'd4);

        // Wrapping burst across word 63 -> 0
        send_cmd(3'd2, 31'd62, 8'd3, 4'd1, 3'd0);
        wr_q.push_back(256'd1); wr_q.push_back(256'd2);
        wr_q.push_back(256'd3); wr_q.push_back(256'd4);
        write_burst(4'd1);
        send_cmd(3'd1, 31'd62, 8'd3, 4'd2, 3'd2);
        exp_q.push_back(256'd1); exp_q.push_back(256'd2);
        exp_q.push_back(256'd3); exp_q.push_back(256'd4);
        read_expect(4, 4'd2, 3'd2);
        // word 0 alone must hold the third beat
        send_cmd(3'd1, 31'd64, 8'd0, 4'd4, 3'd0);
        exp_q.push_back(256'd3);
        read_expect(1, 4'd4, 3'd0);

        // Back-pressure on beat 0
        send_cmd(3'd2, 31'd10, 8'd1, 4'd0, 3'd0);
        wr_q.push_back(256'h111); wr_q.push_back(256'h222);
        write_burst(4'd0);
        rreqStall = 1'b1;
        send_cmd(3'd1, 31'd10, 8'd1, 4'd5, 3'd3);
        wait_valid("bp_wait");
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", rreqValid, 1);
            check("bp_data", rreqData, 256'h111);
            check("bp_id", rreqId, 4'd5);
            if (i < 4) tick();
        end
        rreqStall = 1'b0;
        tick();
        check("bp_gap", rreqValid, 0);
        tick();
        check("bp_beat1_valid", rreqValid, 1);
        check("bp_beat1_data", rreqData, 256'h222);
        tick();
        check("bp_end", rreqValid, 0);

        // Read FIFO full
        rreqStall = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            send_cmd(3'd1, 31'd5, 8'd0, 4'(k), 3'd0);
            check("full_rdstall", creqRdStall, (k == 5) ? 1 : 0);
        end
        creqType = 3'd1; creqAddr = 31'd5; creqSize = 8'd0; creqId = 4'd6; creqValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_held", creqRdStall, 1);
            check("full_wrstall", creqWrStall, 0);
        end
        creqValid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(256'hA5);
            read_expect(1, 4'(k), 3'd0);
        end
        for (int i = 0; i < 6; i++) tick();
        check("full_no_sixth", rreqValid, 0);
        check("full_drained", creqRdStall, 0);

        // Illegal type and error status
        send_cmd(3'd5, 31'd5, 8'd0, 4'd9, 3'd0);
`ifdef NAXI_SLV_ERRCHK_EN
        check("err_type", errStatus, 3'b001);
`else
        check("err_off_type", errStatus, 3'b000);
`endif
        for (int i = 0; i < 4; i++) tick();
        check("illegal_no_read", rreqValid, 0);
        check("illegal_no_write", dreqStall, 1);
        send_cmd(3'd2, 31'd20, 8'd0, 4'd2, 3'd0);
        wr_q.push_back(256'h55);
        write_burst(4'd1);
`ifdef NAXI_SLV_ERRCHK_EN
        check("err_id", errStatus, 3'b011);
        rst = 1'b1; tick(); rst = 1'b0;
        check("err_rst", errStatus, 3'b000);
`else
        check("err_off_id", errStatus, 3'b000);
`endif
        send_cmd(3'd1, 31'd20, 8'd0, 4'd8, 3'd1);
        exp_q.push_back(256'h55);
        read_expect(1, 4'd8, 3'd1);

        // Reset during SEND of beat 1
        send_cmd(3'd2, 31'd30, 8'd3, 4'd0, 3'd0);
        wr_q.push_back(256'hA0); wr_q.push_back(256'hA1);
        wr_q.push_back(256'hA2); wr_q.push_back(256'hA3);
        write_burst(4'd0);
        send_cmd(3'd1, 31'd30, 8'd3, 4'd9, 3'd0);
        wait_valid("mid_beat0");
        tick();
        tick();
        check("mid_beat1_valid", rreqValid, 1);
        check("mid_beat1_data", rreqData, 256'hA1);
        rst = 1'b1;
        tick();
        check("mid_rst_rvalid", rreqValid, 0);
        check("mid_rst_dstall", dreqStall, 1);
        check("mid_rst_rid", rreqId, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_rst_idle", rreqValid, 0);
        send_cmd(3'd1, 31'd30, 8'd3, 4'd3, 3'd5);
        exp_q.push_back(256'hA0); exp_q.push_back(256'hA1);
        exp_q.push_back(256'hA2); exp_q.push_back(256'hA3);
        read_expect(4, 4'd3, 3'd5);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
